// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch front end: reset PC,
// queue entry layout and the canonical NOP encoding.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0100_0000;
  localparam logic [31:0] NOP_INST     = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous ring-buffer FIFO with occupancy count and a synchronous flush.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // NOTE: storage is not reset; entries are only observable once count says they were written.
  always_ff @(posedge clock) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC generation, credit-limited in-order memory
// requests, and a decode queue. Optional macro FETCH_QUEUE_BYPASS_EN lets a
// response reach deq_* in the same cycle when the queue is empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  output logic              deq_valid,
  input  logic              deq_ready,
  output logic [INST_W-1:0] deq_inst,
  output logic [ADDR_W-1:0] deq_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);

  localparam int             CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0]    DEPTH_W = (CW + 1)'(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  logic [ADDR_W-1:0] fetch_pc;
  logic [CW-1:0]     drop;
  logic [CW-1:0]     inflight;
  logic [CW-1:0]     occupancy;
  logic [ADDR_W-1:0] pc_head;
  entry_t            q_head;
  entry_t            q_wdata;
  logic              pc_full, pc_empty, q_full, q_empty;
  logic              issue_ok, req_fire, rsp_keep, bypass, q_push, q_pop;

  // Credits: queued plus in-flight instructions never exceed DEPTH, so the queue cannot overflow.
  assign issue_ok       = !redirect_valid && (({1'b0, occupancy} + {1'b0, inflight}) < DEPTH_W);
  assign imem_req_valid = issue_ok && !reset;
  assign req_fire       = issue_ok && imem_req_ready;
  assign imem_req_addr  = fetch_pc;

  assign rsp_keep = imem_rsp_valid && !redirect_valid && (drop == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = q_empty && rsp_keep;
`else
  assign bypass = 1'b0;
`endif

  assign q_push  = rsp_keep && !(bypass && deq_ready);
  assign q_pop   = !q_empty && deq_ready;
  assign q_wdata = '{pc: pc_head, inst: imem_rsp_data};

  assign deq_valid = !q_empty || bypass;
  assign deq_inst  = !q_empty ? q_head.inst : (bypass ? imem_rsp_data : '0);
  assign deq_pc    = !q_empty ? q_head.pc   : (bypass ? pc_head       : RESET_PC);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      drop     <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
      // Everything still outstanding after this cycle's response belongs to the old stream.
      drop     <= inflight - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + ADDR_W'(4);
      if (imem_rsp_valid && drop != '0) drop <= drop - CW'(1);
    end
  end

  sync_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_pc_fifo (
    .clock     (clock),
    .reset     (reset),
    .clear     (1'b0),
    .push      (req_fire),
    .push_data (fetch_pc),
    .pop       (imem_rsp_valid),
    .pop_data  (pc_head),
    .count     (inflight),
    .full      (pc_full),
    .empty     (pc_empty)
  );

  sync_fifo #(.WIDTH($bits(entry_t)), .DEPTH(DEPTH)) u_inst_queue (
    .clock     (clock),
    .reset     (reset),
    .clear     (redirect_valid),
    .push      (q_push),
    .push_data (q_wdata),
    .pop       (q_pop),
    .pop_data  (q_head),
    .count     (occupancy),
    .full      (q_full),
    .empty     (q_empty)
  );

  a_rsp_has_request: assert property (@(posedge clock) disable iff (reset) !(imem_rsp_valid && pc_empty));
  a_req_has_slot:    assert property (@(posedge clock) disable iff (reset) !(req_fire && pc_full));
  a_queue_no_ovf:    assert property (@(posedge clock) disable iff (reset) !(rsp_keep && q_full));

endmodule
